// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the multi-port SDRAM arbiter (sdram_axi_mport_arb).
package sdram_arb_pkg;

   localparam int STRB_W = 4;
   localparam int LEN_W  = 8;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   // Ceiling log2 with a floor of 1, so a 2-entry space still gets a 1-bit index.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((32'sd1 << width) < value) width = width + 1;
      return width;
   endfunction

endpackage

// File: rtl/sdram_arb_idfifo.sv
// In-order FIFO of granted port IDs; the head names the port that owns the next core ack.
module sdram_arb_idfifo
   import sdram_arb_pkg::*;
#(
   parameter int ID_W  = 2,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic [ID_W-1:0] push_id_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output logic [ID_W-1:0] head_o
);

   localparam int PTR_W = clog2(DEPTH);

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [ID_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign head_o    = mem_q[rd_ptr_q];
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_id_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sdram_axi_mport_arb.sv
// N-port burst-locked round-robin arbiter in front of one sdram_axi_core inport, with in-order
// ack routing. Define SDRAM_ARB_PRIO_EN to give port 0 absolute priority whenever idle.
module sdram_axi_mport_arb
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int OUTSTANDING = 4
) (
   input  logic                        ACLK,
   input  logic                        ARSTN,
   input  logic [STRB_W*NUM_PORTS-1:0] in_wr_i,
   input  logic [NUM_PORTS-1:0]        in_rd_i,
   input  logic [LEN_W*NUM_PORTS-1:0]  in_len_i,
   input  logic [ADDR_W*NUM_PORTS-1:0] in_addr_i,
   input  logic [DATA_W*NUM_PORTS-1:0] in_write_data_i,
   output logic [NUM_PORTS-1:0]        in_accept_o,
   output logic [NUM_PORTS-1:0]        in_ack_o,
   output logic [NUM_PORTS-1:0]        in_error_o,
   output logic [DATA_W-1:0]           in_read_data_o,
   output logic [STRB_W-1:0]           ram_wr_o,
   output logic                        ram_rd_o,
   output logic [LEN_W-1:0]            ram_len_o,
   output logic [ADDR_W-1:0]           ram_addr_o,
   output logic [DATA_W-1:0]           ram_write_data_o,
   input  logic                        ram_accept_i,
   input  logic                        ram_ack_i,
   input  logic                        ram_error_i,
   input  logic [DATA_W-1:0]           ram_read_data_i,
   output logic                        stat_spurious_o
);

   localparam int ID_W = clog2(NUM_PORTS);
`ifdef SDRAM_ARB_PRIO_EN
   localparam int RR_FIRST = 1;
`else
   localparam int RR_FIRST = 0;
`endif

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  gnt_q, gnt_d, rr_q, rr_d;
   logic [ID_W-1:0]  pick_s, cand_s, gnt_s, head_s;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic             spur_q, spur_d;
   logic [NUM_PORTS-1:0] req_s;
   logic [STRB_W-1:0] sel_wr_s;
   logic              sel_rd_s;
   logic [LEN_W-1:0]  sel_len_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_data_s;
   logic found_s, full_s, empty_s, accept_s, pop_s;

   function automatic logic [ID_W-1:0] next_port(input logic [ID_W-1:0] p);
      logic [ID_W-1:0] n;
      if (p == ID_W'(NUM_PORTS - 1)) n = ID_W'(RR_FIRST);
      else                           n = p + ID_W'(1'b1);
      return n;
   endfunction

   always_comb begin
      req_s = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         req_s[p] = (|in_wr_i[p*STRB_W +: STRB_W]) | in_rd_i[p];
   end

   // Rotating search from rr_q; with priority enabled port 0 pre-empts and is skipped by the rotation.
   always_comb begin
      pick_s  = rr_q;
      cand_s  = rr_q;
      found_s = 1'b0;
`ifdef SDRAM_ARB_PRIO_EN
      if (req_s[0]) begin
         pick_s  = '0;
         found_s = 1'b1;
      end else begin
         found_s = 1'b0;
      end
`endif
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand_s = ID_W'((int'(rr_q) + i) % NUM_PORTS);
         if (!found_s && req_s[cand_s] && (int'(cand_s) >= RR_FIRST)) begin
            pick_s  = cand_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign gnt_s = (state_q == ARB_BURST) ? gnt_q : pick_s;

   always_comb begin
      sel_wr_s   = '0;
      sel_rd_s   = 1'b0;
      sel_len_s  = '0;
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_s == ID_W'(p)) begin
            sel_wr_s   = in_wr_i[p*STRB_W +: STRB_W];
            sel_rd_s   = in_rd_i[p];
            sel_len_s  = in_len_i[p*LEN_W +: LEN_W];
            sel_addr_s = in_addr_i[p*ADDR_W +: ADDR_W];
            sel_data_s = in_write_data_i[p*DATA_W +: DATA_W];
         end else begin
            sel_rd_s = sel_rd_s;
         end
      end
   end

   assign accept_s = req_s[gnt_s] & ram_accept_i & ~full_s;
   assign pop_s    = ram_ack_i & ~empty_s;

   assign ram_wr_o         = (ARSTN && !full_s) ? sel_wr_s : '0;
   assign ram_rd_o         = ARSTN & ~full_s & sel_rd_s;
   assign ram_len_o        = sel_len_s;
   assign ram_addr_o       = sel_addr_s;
   assign ram_write_data_o = sel_data_s;
   assign in_read_data_o   = ram_read_data_i;
   assign stat_spurious_o  = spur_q;

   // Strobes are forced low by ARSTN directly so they stay quiet during an asynchronous reset.
   always_comb begin
      in_accept_o         = '0;
      in_ack_o            = '0;
      in_error_o          = '0;
      in_accept_o[gnt_s]  = ARSTN & accept_s;
      in_ack_o[head_s]    = ARSTN & pop_s;
      in_error_o[head_s]  = ARSTN & pop_s & ram_error_i;
   end

   sdram_arb_idfifo #(
      .ID_W  (ID_W),
      .DEPTH (OUTSTANDING)
   ) u_idfifo (
      .clk       (ACLK),
      .rst_n     (ARSTN),
      .push_i    (accept_s),
      .push_id_i (gnt_s),
      .pop_i     (pop_s),
      .full_o    (full_s),
      .empty_o   (empty_s),
      .head_o    (head_s)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      beat_d  = beat_q;
      rr_d    = rr_q;
      spur_d  = spur_q | (ram_ack_i & empty_s);
      case (state_q)
         ARB_IDLE: begin
            if (accept_s && (sel_len_s != '0)) begin
               state_d = ARB_BURST;
               gnt_d   = gnt_s;
               beat_d  = sel_len_s;
            end else if (accept_s) begin
               rr_d = next_port(gnt_s);
            end else begin
               rr_d = rr_q;
            end
         end
         ARB_BURST: begin
            if (accept_s) begin
               beat_d = beat_q - LEN_W'(1'b1);
               if (beat_q == LEN_W'(1'b1)) begin
                  state_d = ARB_IDLE;
                  rr_d    = next_port(gnt_q);
               end else begin
                  state_d = ARB_BURST;
               end
            end else begin
               beat_d = beat_q;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARSTN) begin
      if (!ARSTN) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         beat_q  <= '0;
         rr_q    <= '0;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         beat_q  <= beat_d;
         rr_q    <= rr_d;
         spur_q  <= spur_d;
      end
   end

endmodule

// File: tb/tb_sdram_axi_mport_arb.sv
// Directed plus randomized bench for sdram_axi_mport_arb against a queue-based reference model.
module tb_sdram_axi_mport_arb;

   localparam int N   = 4;
   localparam int OUT = 4;
   localparam int DW  = 32;
   localparam int AW  = 32;

   logic              ACLK = 1'b0;
   logic              ARSTN;
   logic [4*N-1:0]    in_wr_i;
   logic [N-1:0]      in_rd_i;
   logic [8*N-1:0]    in_len_i;
   logic [AW*N-1:0]   in_addr_i;
   logic [DW*N-1:0]   in_write_data_i;
   logic [N-1:0]      in_accept_o, in_ack_o, in_error_o;
   logic [DW-1:0]     in_read_data_o;
   logic [3:0]        ram_wr_o;
   logic              ram_rd_o;
   logic [7:0]        ram_len_o;
   logic [AW-1:0]     ram_addr_o;
   logic [DW-1:0]     ram_write_data_o;
   logic              ram_accept_i, ram_ack_i, ram_error_i;
   logic [DW-1:0]     ram_read_data_i;
   logic              stat_spurious_o;

   int tests = 0;
   int fails = 0;

   // Reference model: outstanding owners, burst owner (-1 when idle), beats left, rotation start.
   int idq[$];
   int m_burst, m_left, m_rr;
   bit m_spur;
   bit auto_ack;
   logic [N-1:0] last_acc, last_ack;

   always #5 ACLK = ~ACLK;

   sdram_axi_mport_arb #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .OUTSTANDING(OUT)) dut (
      .ACLK(ACLK), .ARSTN(ARSTN),
      .in_wr_i(in_wr_i), .in_rd_i(in_rd_i), .in_len_i(in_len_i), .in_addr_i(in_addr_i),
      .in_write_data_i(in_write_data_i), .in_accept_o(in_accept_o), .in_ack_o(in_ack_o),
      .in_error_o(in_error_o), .in_read_data_o(in_read_data_o),
      .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_len_o(ram_len_o), .ram_addr_o(ram_addr_o),
      .ram_write_data_o(ram_write_data_o), .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i),
      .ram_error_i(ram_error_i), .ram_read_data_i(ram_read_data_i),
      .stat_spurious_o(stat_spurious_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit req_of(input int p);
      return (|in_wr_i[4*p +: 4]) || in_rd_i[p];
   endfunction

   function automatic int len_of(input int p);
      return int'(in_len_i[8*p +: 8]);
   endfunction

   function automatic int nxt(input int p);
      int n;
      n = (p + 1) % N;
`ifdef SDRAM_ARB_PRIO_EN
      if (n == 0) n = 1;
`endif
      return n;
   endfunction

   function automatic int model_grant();
      if (m_burst >= 0) return m_burst;
`ifdef SDRAM_ARB_PRIO_EN
      if (req_of(0)) return 0;
`endif
      for (int i = 0; i < N; i++) begin
         int p;
         p = (m_rr + i) % N;
`ifdef SDRAM_ARB_PRIO_EN
         if (p != 0 && req_of(p)) return p;
`else
         if (req_of(p)) return p;
`endif
      end
      return -1;
   endfunction

   task automatic set_port(input int p, input logic [3:0] wr, input logic rd, input logic [7:0] len);
      in_wr_i[4*p +: 4]          = wr;
      in_rd_i[p]                 = rd;
      in_len_i[8*p +: 8]         = len;
      in_addr_i[AW*p +: AW]      = $urandom;
      in_write_data_i[DW*p +: DW] = $urandom;
   endtask

   task automatic clear_ports();
      for (int p = 0; p < N; p++) set_port(p, 4'h0, 1'b0, 8'd0);
   endtask

   task automatic do_reset();
      ram_ack_i = 1'b1;
      ARSTN = 1'b0;
      #1;
      chk("rst_accept", 64'(in_accept_o), 64'd0);
      chk("rst_ack",    64'(in_ack_o),    64'd0);
      chk("rst_error",  64'(in_error_o),  64'd0);
      chk("rst_ram_wr", 64'(ram_wr_o),    64'd0);
      chk("rst_ram_rd", 64'(ram_rd_o),    64'd0);
      idq.delete();
      m_burst = -1; m_left = 0; m_rr = 0; m_spur = 1'b0;
      @(posedge ACLK);
      @(posedge ACLK);
      #1;
      ram_ack_i = 1'b0;
      ARSTN = 1'b1;
   endtask

   // One clock: check combinational outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      int g;
      bit full, acc, pop;
      logic [N-1:0] ea, ek, ee;
      if (auto_ack) ram_ack_i = (idq.size() != 0);
      ram_read_data_i = $urandom;
      ram_error_i     = ($urandom_range(0, 3) == 0);
      @(negedge ACLK);
      g    = model_grant();
      full = (idq.size() == OUT);
      acc  = (g >= 0) && req_of(g) && ram_accept_i && !full;
      ea   = acc ? (N'(1) << g) : '0;
      pop  = ram_ack_i && (idq.size() != 0);
      ek   = pop ? (N'(1) << idq[0]) : '0;
      ee   = (pop && ram_error_i) ? ek : '0;
      chk("accept", 64'(in_accept_o), 64'(ea));
      chk("ack",    64'(in_ack_o),    64'(ek));
      chk("error",  64'(in_error_o),  64'(ee));
      chk("spurious", 64'(stat_spurious_o), 64'(m_spur));
      if (g >= 0 && !full) begin
         chk("ram_wr", 64'(ram_wr_o), 64'(in_wr_i[4*g +: 4]));
         chk("ram_rd", 64'(ram_rd_o), 64'(in_rd_i[g]));
         if (req_of(g)) begin
            chk("ram_len",  64'(ram_len_o),  64'(in_len_i[8*g +: 8]));
            chk("ram_addr", 64'(ram_addr_o), 64'(in_addr_i[AW*g +: AW]));
            chk("ram_data", 64'(ram_write_data_o), 64'(in_write_data_i[DW*g +: DW]));
         end
      end else begin
         chk("ram_wr_off", 64'(ram_wr_o), 64'd0);
         chk("ram_rd_off", 64'(ram_rd_o), 64'd0);
      end
      if (pop) chk("rdata", 64'(in_read_data_o), 64'(ram_read_data_i));
      last_acc = in_accept_o;
      last_ack = in_ack_o;
      @(posedge ACLK);
      if (ram_ack_i) begin
         if (idq.size() == 0) m_spur = 1'b1;
         else void'(idq.pop_front());
      end
      if (acc) begin
         idq.push_back(g);
         if (m_burst >= 0) begin
            m_left--;
            if (m_left == 0) begin
               m_burst = -1;
               m_rr    = nxt(g);
            end
         end else if (len_of(g) != 0) begin
            m_burst = g;
            m_left  = len_of(g);
         end else begin
            m_rr = nxt(g);
         end
      end
      #1;
   endtask

   initial begin
      logic [N-1:0] acc_log [6];
      logic [N-1:0] ack_log [3];
      int cnt, r;
      logic [7:0] ln;

      ARSTN = 1'b0; auto_ack = 1'b0;
      ram_accept_i = 1'b1; ram_ack_i = 1'b0; ram_error_i = 1'b0; ram_read_data_i = '0;
      in_wr_i = '0; in_rd_i = '0; in_len_i = '0; in_addr_i = '0; in_write_data_i = '0;
      set_port(1, 4'hF, 1'b0, 8'd2);
      do_reset();

      // Test 1: ports 0 and 2 single reads
      clear_ports();
      set_port(0, 4'h0, 1'b1, 8'd0);
      set_port(2, 4'h0, 1'b1, 8'd0);
      for (int i = 0; i < 3; i++) begin step(); acc_log[i] = last_acc; end
      clear_ports();
      ram_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); ack_log[i] = last_ack; end
      ram_ack_i = 1'b0;
      chk("t1_gnt0", 64'(acc_log[0]), 64'h1);
      chk("t1_gnt1", 64'(acc_log[1]), 64'h4);
      chk("t1_gnt2", 64'(acc_log[2]), 64'h1);
      chk("t1_ack0", 64'(ack_log[0]), 64'h1);
      chk("t1_ack1", 64'(ack_log[1]), 64'h4);
      chk("t1_ack2", 64'(ack_log[2]), 64'h1);

      // Test 2: port 1 burst len=3 holds the grant against port 3
      set_port(1, 4'hF, 1'b0, 8'd3);
      set_port(3, 4'h0, 1'b1, 8'd0);
      auto_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin step(); acc_log[i] = last_acc; end
      clear_ports();
      step(); step();
      auto_ack = 1'b0; ram_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) chk("t2_burst", 64'(acc_log[i]), 64'h2);
      chk("t2_next", 64'(acc_log[4]), 64'h8);

      // Test 3: FIFO full back-pressure
      for (int p = 0; p < N; p++) set_port(p, 4'h0, 1'b1, 8'd0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin step(); cnt += $countones(last_acc); end
      chk("t3_fill", 64'(cnt), 64'd4);
      chk("t3_stall", 64'(last_acc), 64'd0);
      ram_ack_i = 1'b1; step();
      chk("t3_full_pop", 64'(last_acc), 64'd0);
      ram_ack_i = 1'b0; step();
      chk("t3_one_slot", 64'($countones(last_acc)), 64'd1);
      step();
      chk("t3_refull", 64'(last_acc), 64'd0);
      clear_ports();
      ram_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) step();
      ram_ack_i = 1'b0;

      // Test 4: spurious ack with empty FIFO
      ram_ack_i = 1'b1; step();
      chk("t4_noack", 64'(last_ack), 64'd0);
      ram_ack_i = 1'b0; step();
      chk("t4_sticky", 64'(stat_spurious_o), 64'd1);
      for (int i = 0; i < 3; i++) step();
      chk("t4_held", 64'(stat_spurious_o), 64'd1);

      // Test 5: reset mid-burst
      do_reset();
      step();
      chk("t5_spur_clr", 64'(stat_spurious_o), 64'd0);
      set_port(2, 4'h0, 1'b1, 8'd5);
      step(); step();
      do_reset();
      clear_ports();
      set_port(2, 4'h0, 1'b1, 8'd0);
      step();
      chk("t5_regrant", 64'(last_acc), 64'h4);
      clear_ports();
      ram_ack_i = 1'b1; step();
      chk("t5_ack", 64'(last_ack), 64'h4);
      ram_ack_i = 1'b0; step();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < N; p++) begin
            r  = $urandom_range(0, 3);
            ln = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            if (r == 0)      set_port(p, 4'($urandom_range(1, 15)), 1'b0, ln);
            else if (r == 1) set_port(p, 4'h0, 1'b1, ln);
            else             set_port(p, 4'h0, 1'b0, 8'd0);
         end
         ram_accept_i = ($urandom_range(0, 3) != 0);
         ram_ack_i    = 1'($urandom_range(0, 1));
         step();
      end
      clear_ports();
      ram_accept_i = 1'b1;
      auto_ack = 1'b1;
      for (int i = 0; i < 8; i++) step();

      // Test 6: ports 0 and 1 always requesting
      do_reset();
      set_port(0, 4'h0, 1'b1, 8'd0);
      set_port(1, 4'h0, 1'b1, 8'd0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin step(); cnt += int'(last_acc[0]); end
`ifdef SDRAM_ARB_PRIO_EN
      chk("t6_port0_wins", 64'(cnt), 64'd6);
`else
      chk("t6_alternate", 64'(cnt), 64'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
